detect_burst_monitor: RTL and testbench

Downstream consumer of the three-consecutive-ones Mealy detector: it samples that stage's registered `detect` output and turns the pulse stream into statistics. It keeps a saturating total event count, measures the gap in cycles between successive detections, and raises a sticky alarm when `threshold` detections occur within a `window`-cycle interval. It sits between the detector and the status/interrupt logic.

---
 rtl/detect_burst_monitor.sv | 172 +++++++++++++++++
 tb/tb_detect_burst_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_burst_monitor.sv
`default_nettype none
// ============================================================================
// Module   : detect_burst_monitor
// Function : Statistics stage behind the three-ones detector. Counts detect
//            events (saturating), measures the gap between successive events
//            and raises a sticky alarm when enough events land inside one
//            observation window.
// Revision : 1.0 - initial release
// ============================================================================
module detect_burst_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detect,
  input  logic             clear,
  input  logic [CNT_W-1:0] threshold,
  input  logic [WIN_W-1:0] window,
  output logic [CNT_W-1:0] event_count,
  output logic [WIN_W-1:0] last_gap,
  output logic             gap_valid,
  output logic             burst_alarm,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WINDOW = 2'd1,
    S_ALARM  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;
  localparam logic [WIN_W-1:0] c_WIN_MAX     = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   c_CNT_ONE_EXT = (CNT_W+1)'(1);
  localparam logic [WIN_W:0]   c_WIN_ONE_EXT = (WIN_W+1)'(1);

  state_t             r_state;
  logic               r_seen;
  logic [WIN_W-1:0]   r_gap_cnt;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [WIN_W-1:0]   r_elapsed;

  logic [CNT_W:0]     w_thr_eff;
  logic               w_thr_is_one;
  logic [CNT_W:0]     w_burst_inc;
  logic [CNT_W-1:0]   w_burst_sat;
  logic [WIN_W:0]     w_elapsed_inc;
  logic               w_expired;
  logic               w_win_live;
  logic [CNT_W:0]     w_count_inc;
  logic [CNT_W-1:0]   w_count_sat;
  logic [WIN_W:0]     w_gap_inc;
  logic [WIN_W-1:0]   w_gap_sat;

  // Arithmetic is one bit wider than the stored value so carries become
  // saturation and comparisons never wrap.
  always_comb begin
    w_thr_eff     = (threshold == '0) ? c_CNT_ONE_EXT : {1'b0, threshold};
    w_thr_is_one  = (w_thr_eff == c_CNT_ONE_EXT);
    w_burst_inc   = {1'b0, r_burst_cnt} + c_CNT_ONE_EXT;
    w_burst_sat   = w_burst_inc[CNT_W] ? c_CNT_MAX : w_burst_inc[CNT_W-1:0];
    w_elapsed_inc = {1'b0, r_elapsed} + c_WIN_ONE_EXT;
    w_expired     = (w_elapsed_inc > {1'b0, window});
    w_win_live    = (r_state == S_WINDOW) && !w_expired;
    w_count_inc   = {1'b0, event_count} + c_CNT_ONE_EXT;
    w_count_sat   = w_count_inc[CNT_W] ? c_CNT_MAX : w_count_inc[CNT_W-1:0];
    w_gap_inc     = {1'b0, r_gap_cnt} + c_WIN_ONE_EXT;
    w_gap_sat     = w_gap_inc[WIN_W] ? c_WIN_MAX : w_gap_inc[WIN_W-1:0];
  end

  // Saturating event counter; runs in every FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      event_count <= '0;
    end else if (clear) begin
      event_count <= '0;
    end else if (detect) begin
      event_count <= w_count_sat;
    end
  end

  // Inter-event gap timer; the first event only arms it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen    <= 1'b0;
      r_gap_cnt <= '0;
      last_gap  <= '0;
      gap_valid <= 1'b0;
    end else if (clear) begin
      r_seen    <= 1'b0;
      r_gap_cnt <= '0;
      last_gap  <= '0;
      gap_valid <= 1'b0;
    end else begin
      gap_valid <= 1'b0;
      if (detect) begin
        r_seen    <= 1'b1;
        r_gap_cnt <= '0;
        if (r_seen) begin
          last_gap  <= w_gap_sat;
          gap_valid <= 1'b1;
        end
      end else if (r_seen) begin
        r_gap_cnt <= w_gap_sat;
      end
    end
  end

  // Burst FSM with registered busy/alarm; an expired window is treated like
  // IDLE so an event in that cycle immediately opens a fresh window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_elapsed   <= '0;
      busy        <= 1'b0;
      burst_alarm <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_elapsed   <= '0;
      busy        <= 1'b0;
      burst_alarm <= 1'b0;
    end else begin
      case (r_state)
        S_ALARM: begin
          busy        <= 1'b0;
          burst_alarm <= 1'b1;
        end
        S_IDLE, S_WINDOW: begin
          if (w_win_live) begin
            r_elapsed <= w_elapsed_inc[WIN_W-1:0];
            if (detect) begin
              if (w_burst_inc >= w_thr_eff) begin
                r_state     <= S_ALARM;
                busy        <= 1'b0;
                burst_alarm <= 1'b1;
              end else begin
                r_burst_cnt <= w_burst_sat;
              end
            end
          end else if (detect) begin
            r_burst_cnt <= c_CNT_ONE;
            r_elapsed   <= '0;
            if (w_thr_is_one) begin
              r_state     <= S_ALARM;
              busy        <= 1'b0;
              burst_alarm <= 1'b1;
            end else begin
              r_state     <= S_WINDOW;
              busy        <= 1'b1;
              burst_alarm <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            burst_alarm <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          burst_alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detect_burst_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_detect_burst_monitor
// Function : Self-checking bench for detect_burst_monitor: constant vector
//            table, directed corner sequences and a randomized run against
//            an event-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_detect_burst_monitor;

  logic       clk;
  logic       reset;
  logic       detect;
  logic       clear;
  logic [7:0] threshold;
  logic [7:0] window;
  logic [7:0] event_count;
  logic [7:0] last_gap;
  logic       gap_valid;
  logic       burst_alarm;
  logic       busy;

  detect_burst_monitor #(.CNT_W(8), .WIN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .detect     (detect),
    .clear      (clear),
    .threshold  (threshold),
    .window     (window),
    .event_count(event_count),
    .last_gap   (last_gap),
    .gap_valid  (gap_valid),
    .burst_alarm(burst_alarm),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: works on absolute cycle indices of events.
  int m_t;
  bit m_seen;
  int m_last_t;
  int m_count;
  bit m_gv;
  int m_lg;
  bit m_open;
  bit m_alarm;
  int m_start;
  int m_bcnt;

  typedef struct {
    logic       det;
    logic       clr;
    logic [7:0] thr;
    logic [7:0] win;
    logic [7:0] cnt;
    logic       gv;
    logic [7:0] lg;
    logic       al;
    logic       by;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic d, c, input logic [7:0] t, w,
                              input logic [7:0] cnt, input logic gv,
                              input logic [7:0] lg, input logic al, by);
    vec_t v;
    v.det = d; v.clr = c; v.thr = t; v.win = w;
    v.cnt = cnt; v.gv = gv; v.lg = lg; v.al = al; v.by = by;
    return v;
  endfunction

  task automatic model_reset();
    m_seen = 0; m_last_t = 0; m_count = 0; m_gv = 0; m_lg = 0;
    m_open = 0; m_alarm = 0; m_start = 0; m_bcnt = 0;
  endtask

  task automatic model_step(input logic d, c, input int thr, win);
    int thr_e;
    m_t++;
    if (c) begin
      model_reset();
      return;
    end
    m_gv = 0;
    if (d) begin
      m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
      if (m_seen) begin
        m_gv = 1;
        m_lg = (m_t - m_last_t > 255) ? 255 : m_t - m_last_t;
      end
      m_seen   = 1;
      m_last_t = m_t;
    end
    thr_e = (thr == 0) ? 1 : thr;
    if (!m_alarm) begin
      if (m_open && (m_t - m_start) > win) m_open = 0;
      if (m_open && d) begin
        m_bcnt++;
        if (m_bcnt >= thr_e) begin m_alarm = 1; m_open = 0; end
      end else if (!m_open && d) begin
        m_open = 1; m_start = m_t; m_bcnt = 1;
        if (thr_e <= 1) begin m_alarm = 1; m_open = 0; end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic d, c, input logic [7:0] t, w);
    detect = d; clear = c; threshold = t; window = w;
    @(posedge clk);
    model_step(d, c, int'(t), int'(w));
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".event_count"}, event_count, 0);
    chk({tag, ".last_gap"},    last_gap,    0);
    chk({tag, ".gap_valid"},   gap_valid,   0);
    chk({tag, ".burst_alarm"}, burst_alarm, 0);
    chk({tag, ".busy"},        busy,        0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".event_count"}, event_count, m_count);
    chk({tag, ".last_gap"},    last_gap,    m_lg);
    chk({tag, ".gap_valid"},   gap_valid,   m_gv);
    chk({tag, ".burst_alarm"}, burst_alarm, m_alarm);
    chk({tag, ".busy"},        busy,        m_open);
  endtask

  initial begin
    int bad;
    int p;
    logic [7:0] thr_r;
    logic [7:0] win_r;

    // Gap test: thr=10 win=0, events 5 cycles apart.
    vecs.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 10, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 10, 0, 2, 1, 5, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 10, 0, 2, 0, 5, 0, 0));
    vecs.push_back(mk(1, 0, 10, 0, 3, 1, 5, 0, 1));
    // Burst test: thr=3 win=4, events at 0, 2, 4, then 20 idle cycles.
    vecs.push_back(mk(0, 1, 3, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3, 4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 3, 4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 3, 4, 2, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 3, 4, 2, 0, 2, 0, 1));
    vecs.push_back(mk(1, 0, 3, 4, 3, 1, 2, 1, 0));
    for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 0, 3, 4, 3, 0, 2, 1, 0));

    m_t = 0;
    model_reset();
    reset = 1'b0; detect = 0; clear = 0; threshold = 0; window = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      apply(vecs[i].det, vecs[i].clr, vecs[i].thr, vecs[i].win);
      chk($sformatf("vec%0d.event_count", i), event_count, vecs[i].cnt);
      chk($sformatf("vec%0d.gap_valid", i),   gap_valid,   vecs[i].gv);
      chk($sformatf("vec%0d.last_gap", i),    last_gap,    vecs[i].lg);
      chk($sformatf("vec%0d.burst_alarm", i), burst_alarm, vecs[i].al);
      chk($sformatf("vec%0d.busy", i),        busy,        vecs[i].by);
    end

    // Expired window: events at 0, 2, 6 give no alarm; 6 restarts the count.
    apply(0, 1, 3, 4);
    for (int c = 0; c <= 8; c++) begin
      apply((c == 0 || c == 2 || c == 6 || c == 7 || c == 8), 0, 3, 4);
      if (c == 6) begin
        chk("expire.busy6", busy, 1);
        chk("expire.alarm6", burst_alarm, 0);
      end
      if (c == 7) chk("expire.alarm7", burst_alarm, 0);
      if (c == 8) chk("expire.alarm8", burst_alarm, 1);
    end

    // Detect held high with threshold 0.
    apply(0, 1, 0, 5);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      apply(1, 0, 0, 5);
      if (c == 0) begin
        chk("hold.alarm_first", burst_alarm, 1);
        chk("hold.gv_first", gap_valid, 0);
      end else if (gap_valid !== 1'b1 || last_gap !== 8'd1) begin
        bad++;
      end
    end
    chk("hold.gap_stream_bad_cycles", bad, 0);
    chk("hold.event_count_sat", event_count, 255);
    chk("hold.busy", busy, 0);

    // Clear beats detect while in ALARM.
    apply(0, 1, 1, 3);
    for (int c = 0; c < 10; c++) apply(1, 0, 1, 3);
    chk("clr.pre_count", event_count, 10);
    chk("clr.pre_alarm", burst_alarm, 1);
    apply(1, 1, 1, 3);
    chk_zero("clr");
    apply(1, 0, 2, 3);
    chk("clr.after_busy", busy, 1);
    chk("clr.after_count", event_count, 1);
    chk("clr.after_gv", gap_valid, 0);

    // Asynchronous reset between edges, mid-window.
    apply(0, 1, 5, 10);
    apply(1, 0, 5, 10);
    apply(0, 0, 5, 10);
    apply(1, 0, 5, 10);
    chk("arst.pre_busy", busy, 1);
    #3 reset = 1'b0;
    #1 chk_zero("arst");
    model_reset();
    #2 reset = 1'b1;
    apply(1, 0, 5, 10);
    chk("arst.after_count", event_count, 1);
    chk("arst.after_gv", gap_valid, 0);
    chk("arst.after_busy", busy, 1);

    // Randomized run against the reference model.
    thr_r = 3; win_r = 4;
    for (int c = 0; c < 4000; c++) begin
      logic d, cl;
      if ($urandom_range(0, 49) == 0) thr_r = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) win_r = 8'($urandom_range(0, 12));
      p  = (c >= 2500 && c < 3500) ? 400 : 5;
      d  = ($urandom_range(0, p - 1) < 2);
      cl = (c < 2500 && $urandom_range(0, 149) == 0);
      apply(d, cl, thr_r, win_r);
      chk_model($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
